apb_lsu_bridge: RTL and testbench
=================================

Name: apb_lsu_bridge

Overview:
- Parametrised APB4 master sitting between the MEM stage LSU and N external APB slaves.
- Replaces the single-slave, word-only APB path.
- Adds:
  - multi-slave decode
  - byte/halfword strobes (PSTRB)
  - sign/zero-extended load alignment
  - misalignment, decode, PSLVERR and timeout error reporting
- Holds the pipeline via o_stall until each transfer completes.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, data width; fixed at 32 in this generation, with 4 byte lanes.
- NUM_SLV, 4, number of APB slaves; one PSEL bit per slave.
- IDX_LSB, 12, lowest address bit of the slave index field; the field is $clog2(NUM_SLV) bits wide.
- TIMEOUT_CYC, 255, maximum ACCESS cycles before abort (used only with APB_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset; asynchronous, active-low
- i_req  in  1  MEM-stage request that targets the APB window; held stable while o_stall=1
- i_we  in  1  1=store, 0=load
- i_addr  in  ADDR_W  byte address
- i_wdata  in  DATA_W  store data, right-justified
- i_funct3  in  3  RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW encoding
- o_rdata  out  DATA_W  extended load data; valid in DONE
- o_stall  out  1  freezes PC/IF/ID/EX/MEM registers
- o_err  out  1  access fault; valid in DONE
- o_paddr  out  ADDR_W  word-aligned address (addr[1:0]=0)
- o_pwrite  out  1
- o_psel  out  NUM_SLV  one-hot
- o_penable  out  1
- o_pwdata  out  DATA_W  lane-replicated write data
- o_pstrb  out  4  byte strobes; 0 for reads
- i_prdata  in  NUM_SLV*DATA_W  per-slave read data, flat
- i_pready  in  NUM_SLV
- i_pslverr  in  NUM_SLV

Behaviour:
- Reset (i_reset=0, any time including mid-transfer):
  - state=IDLE.
  - o_psel=0, o_penable=0, o_paddr=0, o_pwrite=0, o_pwdata=0, o_pstrb=0, o_rdata=0, o_err=0.
  - Timeout counter=0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- o_stall = i_req && state!=DONE. This is combinational; all other outputs are registered.
- IDLE:
  - If i_req: capture we/addr/wdata/funct3/index.
  - If misaligned or index>=NUM_SLV → DONE with err=1 and rdata=0; no bus activity.
  - Otherwise → SETUP.
  - Misaligned means: halfword with addr[0]=1, or word with addr[1:0]!=0.
- SETUP:
  - psel[idx]=1, penable=0, paddr/pwrite/pwdata/pstrb driven.
  - Next state: ACCESS.
- ACCESS:
  - penable=1.
  - On pready[idx]=1: latch aligned rdata (loads only); err=pslverr[idx]; deassert psel/penable next edge; → DONE.
  - While pready=0: stay, all APB outputs stable.
- DONE: one cycle, o_stall=0, pipeline advances; → IDLE unconditionally.
- Latency: a zero-wait-state transfer stalls for 3 cycles (IDLE, SETUP, ACCESS), then DONE. Back-to-back requests incur a 1-cycle IDLE gap.
- Store alignment:
  - SB: pstrb = 1<<addr[1:0], byte replicated ×4.
  - SH: pstrb = 0011 or 1100 by addr[1], halfword replicated ×2.
  - SW: pstrb = 1111.
- Load alignment: select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Illegal funct3 (3'b011, 3'b110, 3'b111) → error path as misaligned.
- On a store, or on any error, o_rdata=0.
- i_req dropping in SETUP or ACCESS (flush) is ignored: the transfer completes per the APB protocol.

Optional Feature:
- APB_TIMEOUT_EN
- Defined:
  - A counter increments each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYC, psel/penable drop, state → DONE, err=1, rdata=0.
  - Counter clears on entry to SETUP.
- Undefined: no counter; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_pkg:
  - apb_state_e enum.
  - funct3 localparams (F3_B/H/W/BU/HU).
  - Function strb_gen(funct3, addr_lo).
- Sub-module apb_lane_align: combinational store data/strobe generation and load extraction/extension; instantiated once.

Test Plan:
- SW 0xDEADBEEF to 0x0000_1000 (slave 1), pready=1 → psel=0010, pstrb=1111, pwdata=DEADBEEF, stall high for 3 cycles, err=0.
- LB from 0x0000_2003, slave 2 prdata=0x80_11_22_33, 2 wait states → rdata=0xFFFFFF80, stall high for 5 cycles; LBU on the same data → 0x00000080.
- SH 0x1234ABCD to 0x0000_0002 → pstrb=1100, pwdata=ABCDABCD; LH from 0x0000_0001 → no psel, o_err=1 in DONE, rdata=0.
- Load with pslverr[3]=1 at 0x0000_3000 → o_err=1, rdata=0. Index 4 with NUM_SLV=4 → decode error, no psel.
- APB_TIMEOUT_EN defined, TIMEOUT_CYC=8, pready held 0 → psel drops after 8 ACCESS cycles, err=1, stall released.
- Reset asserted in ACCESS → psel/penable/stall=0 immediately; the next i_req starts a fresh transfer at SETUP.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the LSU-to-APB bridge: FSM state encoding,
// RISC-V load/store funct3 codes, byte-strobe generation and access legality.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } apb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Access size lives in funct3[1:0]; reads get their strobes zeroed by the caller.
    function automatic logic [3:0] strb_gen(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   strb_gen = 4'b0001 << addr_lo;
            2'b01:   strb_gen = addr_lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   strb_gen = 4'b1111;
            default: strb_gen = 4'b0000;
        endcase
    endfunction

    // True for a misaligned halfword/word or an encoding that is not a load/store size.
    function automatic logic access_bad(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: access_bad = 1'b0;
            F3_H, F3_HU: access_bad = addr_lo[0];
            F3_W:        access_bad = (addr_lo != 2'b00);
            default:     access_bad = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: store data replication and strobes toward APB, and
// load lane extraction with sign/zero extension back to the LSU.
module apb_lane_align
    import apb_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [31:0] st_pwdata,
    output logic [3:0]  st_pstrb,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_pstrb = strb_gen(st_funct3, st_addr_lo);
        case (st_funct3[1:0])
            2'b00:   st_pwdata = {4{st_data[7:0]}};
            2'b01:   st_pwdata = {2{st_data[15:0]}};
            default: st_pwdata = st_data;
        endcase

        case (ld_addr_lo)
            2'b00:   ld_byte = ld_word[7:0];
            2'b01:   ld_byte = ld_word[15:8];
            2'b10:   ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            F3_W:    ld_data = ld_word;
            default: ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/apb_lsu_bridge.sv
// APB4 master between the MEM-stage LSU and NUM_SLV slaves; holds the pipeline
// via o_stall per transfer. Optional APB_TIMEOUT_EN aborts hung ACCESS phases.
module apb_lsu_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int NUM_SLV     = 4,
    parameter int IDX_LSB     = 12,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    input  logic [2:0]                i_funct3,
    output logic [DATA_W-1:0]         o_rdata,
    output logic                      o_stall,
    output logic                      o_err,
    output logic [ADDR_W-1:0]         o_paddr,
    output logic                      o_pwrite,
    output logic [NUM_SLV-1:0]        o_psel,
    output logic                      o_penable,
    output logic [DATA_W-1:0]         o_pwdata,
    output logic [3:0]                o_pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] i_prdata,
    input  logic [NUM_SLV-1:0]        i_pready,
    input  logic [NUM_SLV-1:0]        i_pslverr,
    output logic [1:0]                o_dbg_state
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam logic [IDX_W:0] SLV_LIM = (IDX_W+1)'(NUM_SLV);

    apb_state_e        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic [IDX_W-1:0]  idx_q;
    // One guard bit above the index field so an index just past the last slave decodes as an error.
    logic [IDX_W:0]    req_idx;
    logic [DATA_W-1:0] st_pwdata;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] sel_prdata;
    logic [3:0]        st_pstrb;
    logic              sel_pready;
    logic              sel_pslverr;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
    logic [TO_W-1:0] to_cnt;
`endif

    assign req_idx     = i_addr[IDX_LSB +: IDX_W+1];
    // Handshake: i_req is held until a cycle with o_stall=0 (DONE); that cycle retires the access.
    assign o_stall     = i_req && (state != ST_DONE);
    assign o_dbg_state = state;

    always_comb begin
        sel_prdata  = '0;
        sel_pready  = 1'b0;
        sel_pslverr = 1'b0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (idx_q == IDX_W'(s)) begin
                sel_prdata  = i_prdata[s*DATA_W +: DATA_W];
                sel_pready  = i_pready[s];
                sel_pslverr = i_pslverr[s];
            end
        end
    end

    apb_lane_align u_align (
        .st_funct3  (i_funct3),
        .st_addr_lo (i_addr[1:0]),
        .st_data    (i_wdata),
        .st_pwdata  (st_pwdata),
        .st_pstrb   (st_pstrb),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .ld_word    (sel_prdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            lo_q      <= 2'b00;
            idx_q     <= '0;
            o_psel    <= '0;
            o_penable <= 1'b0;
            o_paddr   <= '0;
            o_pwrite  <= 1'b0;
            o_pwdata  <= '0;
            o_pstrb   <= 4'b0000;
            o_rdata   <= '0;
            o_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        f3_q    <= i_funct3;
                        lo_q    <= i_addr[1:0];
                        idx_q   <= req_idx[IDX_W-1:0];
                        o_rdata <= '0;
                        o_err   <= 1'b0;
                        if (access_bad(i_funct3, i_addr[1:0]) || (req_idx >= SLV_LIM)) begin
                            o_err <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            o_psel   <= NUM_SLV'(1) << req_idx[IDX_W-1:0];
                            o_paddr  <= {i_addr[ADDR_W-1:2], 2'b00};
                            o_pwrite <= i_we;
                            o_pwdata <= i_we ? st_pwdata : '0;
                            o_pstrb  <= i_we ? st_pstrb : 4'b0000;
`ifdef APB_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                            state    <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    o_penable <= 1'b1;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_pready) begin
                        o_psel    <= '0;
                        o_penable <= 1'b0;
                        o_err     <= sel_pslverr;
                        o_rdata   <= (!we_q && !sel_pslverr) ? ld_data : '0;
                        state     <= ST_DONE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (to_cnt + 1'b1 == TO_LIM) begin
                        o_psel    <= '0;
                        o_penable <= 1'b0;
                        o_err     <= 1'b1;
                        o_rdata   <= '0;
                        state     <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_lsu_bridge.sv
// Directed table-driven bench for apb_lsu_bridge plus hand-written reset,
// flush and (with APB_TIMEOUT_EN) timeout sequences.
module tb_apb_lsu_bridge;

    localparam int NUM_SLV = 4;
    localparam int TO_CYC  = 8;

    logic         i_clk = 1'b0;
    logic         i_reset = 1'b0;
    logic         i_req = 1'b0;
    logic         i_we = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [31:0]  i_wdata = '0;
    logic [2:0]   i_funct3 = '0;
    logic [31:0]  o_rdata;
    logic         o_stall;
    logic         o_err;
    logic [31:0]  o_paddr;
    logic         o_pwrite;
    logic [3:0]   o_psel;
    logic         o_penable;
    logic [31:0]  o_pwdata;
    logic [3:0]   o_pstrb;
    logic [127:0] i_prdata = '0;
    logic [3:0]   i_pready;
    logic [3:0]   i_pslverr = '0;
    logic [1:0]   o_dbg_state;

    always #5 i_clk = ~i_clk;

    apb_lsu_bridge #(
        .ADDR_W(32), .DATA_W(32), .NUM_SLV(NUM_SLV), .IDX_LSB(12), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_funct3(i_funct3), .o_rdata(o_rdata), .o_stall(o_stall),
        .o_err(o_err), .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel),
        .o_penable(o_penable), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb), .i_prdata(i_prdata),
        .i_pready(i_pready), .i_pslverr(i_pslverr), .o_dbg_state(o_dbg_state)
    );

    // Slave model: ready after slv_waits ACCESS cycles.
    int acc_cnt;
    int slv_waits = 0;
    always @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) acc_cnt <= 0;
        else if (o_penable && o_psel != 0) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign i_pready = (o_penable && acc_cnt >= slv_waits) ? o_psel : 4'b0000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic [3:0]  slverr;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
        logic [3:0]  exp_psel;
        logic [3:0]  exp_pstrb;
        logic [31:0] exp_pwdata;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input logic [31:0] rd, input logic [3:0] slverr,
                                input int waits, input logic [31:0] exp_rdata, input logic exp_err,
                                input int exp_stall, input logic [3:0] exp_psel,
                                input logic [3:0] exp_pstrb, input logic [31:0] exp_pwdata);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.rd = rd; v.slverr = slverr;
        v.waits = waits; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_stall = exp_stall;
        v.exp_psel = exp_psel; v.exp_pstrb = exp_pstrb; v.exp_pwdata = exp_pwdata;
        return v;
    endfunction

    // Results of the most recent transfer
    logic [31:0] res_rdata;
    logic        res_err;
    int          res_stall;
    logic [3:0]  cap_psel;
    logic [3:0]  cap_pstrb;
    logic [31:0] cap_pwdata;
    logic [31:0] cap_paddr;
    logic        cap_pwrite;
    int          stable_bad;
    logic        hung;

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, input logic [31:0] rd, input logic [3:0] slverr,
                             input int waits);
        int tgt;
        tgt = int'(addr[13:12]);
        for (int s = 0; s < NUM_SLV; s++) i_prdata[s*32 +: 32] = (s == tgt) ? rd : 32'h5A5A5A5A;
        i_pslverr = slverr;
        slv_waits = waits;
        i_we = we; i_addr = addr; i_wdata = wdata; i_funct3 = f3; i_req = 1'b1;
    endtask

    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3, input logic [31:0] rd, input logic [3:0] slverr,
                          input int waits);
        @(negedge i_clk);
        drive_req(we, addr, wdata, f3, rd, slverr, waits);
        res_stall = 0; cap_psel = '0; cap_pstrb = '0; cap_pwdata = '0; cap_paddr = '0;
        cap_pwrite = 1'b0; stable_bad = 0; hung = 1'b1;
        #1;
        for (int n = 0; n < 60; n++) begin
            if (!o_stall) begin
                hung = 1'b0;
                break;
            end
            res_stall++;
            if (o_psel != 0 && !o_penable) begin
                cap_psel = o_psel; cap_pstrb = o_pstrb; cap_pwdata = o_pwdata;
                cap_paddr = o_paddr; cap_pwrite = o_pwrite;
            end
            if (o_penable && (o_psel != cap_psel || o_paddr != cap_paddr ||
                              o_pwdata != cap_pwdata || o_pstrb != cap_pstrb)) stable_bad++;
            @(negedge i_clk);
            #1;
        end
        res_rdata = o_rdata;
        res_err   = o_err;
        i_req     = 1'b0;
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = mk(1, 32'h0000_1000, 32'hDEADBEEF, 3'b010, 32'h0, 4'h0, 0, 32'h0, 0, 3, 4'b0010, 4'b1111, 32'hDEADBEEF);
        vecs[1]  = mk(0, 32'h0000_2003, 32'h0, 3'b000, 32'h80112233, 4'h0, 2, 32'hFFFFFF80, 0, 5, 4'b0100, 4'b0000, 32'h0);
        vecs[2]  = mk(0, 32'h0000_2003, 32'h0, 3'b100, 32'h80112233, 4'h0, 2, 32'h00000080, 0, 5, 4'b0100, 4'b0000, 32'h0);
        vecs[3]  = mk(1, 32'h0000_0002, 32'h1234ABCD, 3'b001, 32'h0, 4'h0, 0, 32'h0, 0, 3, 4'b0001, 4'b1100, 32'hABCDABCD);
        vecs[4]  = mk(0, 32'h0000_0001, 32'h0, 3'b001, 32'h11111111, 4'h0, 0, 32'h0, 1, 1, 4'b0000, 4'b0000, 32'h0);
        vecs[5]  = mk(0, 32'h0000_3000, 32'h0, 3'b010, 32'h11223344, 4'b1000, 0, 32'h0, 1, 3, 4'b1000, 4'b0000, 32'h0);
        vecs[6]  = mk(0, 32'h0000_4000, 32'h0, 3'b010, 32'h11223344, 4'h0, 0, 32'h0, 1, 1, 4'b0000, 4'b0000, 32'h0);
        vecs[7]  = mk(1, 32'h0000_1001, 32'h000000A5, 3'b000, 32'h0, 4'h0, 0, 32'h0, 0, 3, 4'b0010, 4'b0010, 32'hA5A5A5A5);
        vecs[8]  = mk(0, 32'h0000_2002, 32'h0, 3'b001, 32'h80112233, 4'h0, 1, 32'hFFFF8011, 0, 4, 4'b0100, 4'b0000, 32'h0);
        vecs[9]  = mk(0, 32'h0000_2000, 32'h0, 3'b101, 32'h80112233, 4'h0, 0, 32'h00002233, 0, 3, 4'b0100, 4'b0000, 32'h0);
        vecs[10] = mk(0, 32'h0000_1004, 32'h0, 3'b010, 32'hCAFEF00D, 4'h0, 0, 32'hCAFEF00D, 0, 3, 4'b0010, 4'b0000, 32'h0);
        vecs[11] = mk(0, 32'h0000_1000, 32'h0, 3'b011, 32'hCAFEF00D, 4'h0, 0, 32'h0, 1, 1, 4'b0000, 4'b0000, 32'h0);
        vecs[12] = mk(1, 32'h0000_1002, 32'h55667788, 3'b010, 32'h0, 4'h0, 0, 32'h0, 1, 1, 4'b0000, 4'b0000, 32'h0);
        vecs[13] = mk(0, 32'h0000_0000, 32'h0, 3'b000, 32'h80112233, 4'h0, 0, 32'h00000033, 0, 3, 4'b0001, 4'b0000, 32'h0);
        vecs[14] = mk(1, 32'h0000_2000, 32'h0F0F0F0F, 3'b010, 32'h0, 4'b0100, 0, 32'h0, 1, 3, 4'b0100, 4'b1111, 32'h0F0F0F0F);
        vecs[15] = mk(0, 32'h0000_3001, 32'h0, 3'b000, 32'h80112233, 4'h0, 1, 32'h00000022, 0, 4, 4'b1000, 4'b0000, 32'h0);

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_psel", {28'd0, o_psel}, 32'h0);
        check("rst_penable", {31'd0, o_penable}, 32'h0);
        check("rst_paddr", o_paddr, 32'h0);
        check("rst_pstrb", {28'd0, o_pstrb}, 32'h0);
        check("rst_rdata", o_rdata, 32'h0);
        check("rst_err", {31'd0, o_err}, 32'h0);
        check("rst_state", {30'd0, o_dbg_state}, 32'h0);
        i_reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].rd, vecs[i].slverr, vecs[i].waits);
            check($sformatf("v%0d done", i), {31'd0, hung}, 32'h0);
            check($sformatf("v%0d stall", i), res_stall, vecs[i].exp_stall);
            check($sformatf("v%0d rdata", i), res_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d err", i), {31'd0, res_err}, {31'd0, vecs[i].exp_err});
            check($sformatf("v%0d psel", i), {28'd0, cap_psel}, {28'd0, vecs[i].exp_psel});
            check($sformatf("v%0d pstrb", i), {28'd0, cap_pstrb}, {28'd0, vecs[i].exp_pstrb});
            check($sformatf("v%0d stable", i), stable_bad, 0);
            if (vecs[i].exp_psel != 4'b0000) begin
                check($sformatf("v%0d paddr", i), cap_paddr, {vecs[i].addr[31:2], 2'b00});
                check($sformatf("v%0d pwrite", i), {31'd0, cap_pwrite}, {31'd0, vecs[i].we});
                if (vecs[i].we) check($sformatf("v%0d pwdata", i), cap_pwdata, vecs[i].exp_pwdata);
            end
            check($sformatf("v%0d psel_after", i), {28'd0, o_psel}, 32'h0);
        end

        // Reset asserted in ACCESS, then a fresh transfer
        begin
            int n;
            @(negedge i_clk);
            drive_req(0, 32'h0000_2000, 32'h0, 3'b010, 32'h01020304, 4'h0, 20);
            n = 0;
            while (!o_penable && n < 10) begin
                @(negedge i_clk);
                n++;
            end
            check("rsta_reach_access", {31'd0, o_penable}, 32'h1);
            @(negedge i_clk);
            i_reset = 1'b0;
            i_req   = 1'b0;
            #1;
            check("rsta_psel", {28'd0, o_psel}, 32'h0);
            check("rsta_penable", {31'd0, o_penable}, 32'h0);
            check("rsta_stall", {31'd0, o_stall}, 32'h0);
            check("rsta_state", {30'd0, o_dbg_state}, 32'h0);
            @(negedge i_clk);
            i_reset = 1'b1;
            do_txn(0, 32'h0000_2000, 32'h0, 3'b101, 32'h80112233, 4'h0, 0);
            check("rsta_next_stall", res_stall, 3);
            check("rsta_next_rdata", res_rdata, 32'h00002233);
        end

        // i_req dropped in SETUP: transfer still completes through DONE
        begin
            logic seen_done;
            logic [31:0] done_rdata;
            seen_done  = 1'b0;
            done_rdata = '0;
            @(negedge i_clk);
            drive_req(0, 32'h0000_1000, 32'h0, 3'b010, 32'h0BADF00D, 4'h0, 2);
            @(negedge i_clk);
            i_req = 1'b0;
            check("flush_setup_psel", {28'd0, o_psel}, 32'h2);
            for (int n = 0; n < 20; n++) begin
                @(negedge i_clk);
                if (o_dbg_state == 2'd3) begin
                    seen_done  = 1'b1;
                    done_rdata = o_rdata;
                    break;
                end
            end
            check("flush_done", {31'd0, seen_done}, 32'h1);
            check("flush_rdata", done_rdata, 32'h0BADF00D);
            @(negedge i_clk);
            check("flush_idle", {30'd0, o_dbg_state}, 32'h0);
        end

`ifdef APB_TIMEOUT_EN
        do_txn(0, 32'h0000_1000, 32'h0, 3'b010, 32'h12345678, 4'h0, 1000);
        check("to_done", {31'd0, hung}, 32'h0);
        check("to_stall", res_stall, 2 + TO_CYC);
        check("to_err", {31'd0, res_err}, 32'h1);
        check("to_rdata", res_rdata, 32'h0);
        check("to_psel", {28'd0, o_psel}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
